// File: rtl/cfs_cfg_seq.sv
// rtl/cfs_cfg_seq.sv - APB master that configures the Aligner and services its IRQ register
module cfs_cfg_seq #(
  parameter int APB_ADDR_WIDTH  = 16,
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int TIMEOUT         = 16,
  parameter logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL  = 'h0000,
  parameter logic [APB_ADDR_WIDTH-1:0] ADDR_IRQEN = 'h00f0,
  parameter logic [APB_ADDR_WIDTH-1:0] ADDR_IRQ   = 'h00f4,
  localparam int SW = $clog2(ALGN_DATA_WIDTH/8) + 1,
  localparam int OW = ($clog2(ALGN_DATA_WIDTH/8) > 1) ? $clog2(ALGN_DATA_WIDTH/8) : 1
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      start,
  input  logic [SW-1:0]             cfg_size,
  input  logic [OW-1:0]             cfg_offset,
  input  logic                      cfg_clr,
  input  logic [4:0]                cfg_irqen,
  input  logic                      irq,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [31:0]               pwdata,
  input  logic                      pready,
  input  logic [31:0]               prdata,
  input  logic                      pslverr,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [4:0]                irq_status,
  output logic                      irq_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_DONE
  } state_t;

  // Op indices within the CFG list and the SVC list
  localparam logic [1:0] OP_WR_CTRL  = 2'd0;
  localparam logic [1:0] OP_WR_IRQEN = 2'd1;
  localparam logic [1:0] OP_RD_CTRL  = 2'd2;
  localparam logic [1:0] OP_RD_IRQ   = 2'd0;
  localparam logic [1:0] OP_WR_IRQ   = 2'd1;

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] EC_NONE    = 2'd0;
  localparam logic [1:0] EC_SLVERR  = 2'd1;
  localparam logic [1:0] EC_TIMEOUT = 2'd2;
  localparam logic [1:0] EC_VERIFY  = 2'd3;

  state_t                    r_state;
  logic                      r_svc;
  logic [1:0]                r_op;
  logic [TW-1:0]             r_tmo;
  logic [SW-1:0]             r_size;
  logic [OW-1:0]             r_offset;
  logic                      r_clr;
  logic [4:0]                r_irqen;
  logic [4:0]                r_irq_rd;

  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [31:0]               r_pwdata;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;
  logic [1:0]                r_err_code;
  logic [4:0]                r_irq_status;
  logic                      r_irq_valid;

  logic                      w_idle;
  logic                      w_sel_svc;
  logic [1:0]                w_sel_op;
  logic [SW-1:0]             w_size;
  logic [OW-1:0]             w_offset;
  logic                      w_clr;
  logic [4:0]                w_irqen;
  logic [31:0]               w_ctrl_word;
  logic [APB_ADDR_WIDTH-1:0] w_nxt_addr;
  logic                      w_nxt_write;
  logic [31:0]               w_nxt_wdata;
  logic                      w_last;
  logic                      w_rd_mismatch;
  logic                      w_abort;
  logic [1:0]                w_abort_code;
  logic                      w_unused_prdata;

  assign paddr      = r_paddr;
  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign pwdata     = r_pwdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign irq_status = r_irq_status;
  assign irq_valid  = r_irq_valid;

  // Only a few prdata fields are ever inspected
  assign w_unused_prdata = &{1'b0, prdata};

  // Decode the op about to be launched: op 0 from IDLE (using live cfg inputs), else the next op from GAP
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_sel_svc   = w_idle ? !start : r_svc;
    w_sel_op    = w_idle ? 2'd0 : (r_op + 2'd1);
    w_size      = w_idle ? cfg_size   : r_size;
    w_offset    = w_idle ? cfg_offset : r_offset;
    w_clr       = w_idle ? cfg_clr    : r_clr;
    w_irqen     = w_idle ? cfg_irqen  : r_irqen;

    w_ctrl_word           = '0;
    w_ctrl_word[SW-1:0]   = w_size;
    w_ctrl_word[OW+7:8]   = w_offset;
    w_ctrl_word[16]       = w_clr;

    w_nxt_addr  = ADDR_CTRL;
    w_nxt_write = 1'b0;
    w_nxt_wdata = '0;
    if (w_sel_svc) begin
      w_nxt_addr = ADDR_IRQ;
      if (w_sel_op == OP_WR_IRQ) begin
        // Write back exactly the bits that were read as set
        w_nxt_write = 1'b1;
        w_nxt_wdata = {27'b0, r_irq_rd};
      end
    end else begin
      case (w_sel_op)
        OP_WR_CTRL: begin
          w_nxt_addr  = ADDR_CTRL;
          w_nxt_write = 1'b1;
          w_nxt_wdata = w_ctrl_word;
        end
        OP_WR_IRQEN: begin
          w_nxt_addr  = ADDR_IRQEN;
          w_nxt_write = 1'b1;
          w_nxt_wdata = {27'b0, w_irqen};
        end
        default: begin
          w_nxt_addr  = ADDR_CTRL;
          w_nxt_write = 1'b0;
        end
      endcase
    end

    w_last = r_svc ? (r_op == OP_WR_IRQ) : (r_op == OP_RD_CTRL);
    w_rd_mismatch = (prdata[OW+7:8] != r_offset) || (prdata[SW-1:0] != r_size);
  end

  // Abort decision for the current ACCESS cycle; pslverr outranks the readback check
  always_comb begin
    w_abort      = 1'b0;
    w_abort_code = EC_NONE;
    if (r_state == S_ACCESS) begin
      if (pready) begin
        if (pslverr) begin
          w_abort      = 1'b1;
          w_abort_code = EC_SLVERR;
        end else if (!r_svc && (r_op == OP_RD_CTRL) && w_rd_mismatch) begin
          w_abort      = 1'b1;
          w_abort_code = EC_VERIFY;
        end
      end else if (r_tmo == TW'(TIMEOUT)) begin
        w_abort      = 1'b1;
        w_abort_code = EC_TIMEOUT;
      end
    end
  end

  // Sequencer FSM with all APB and status outputs registered
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state      <= S_IDLE;
      r_svc        <= 1'b0;
      r_op         <= 2'd0;
      r_tmo        <= '0;
      r_size       <= '0;
      r_offset     <= '0;
      r_clr        <= 1'b0;
      r_irqen      <= '0;
      r_irq_rd     <= '0;
      r_paddr      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= EC_NONE;
      r_irq_status <= '0;
      r_irq_valid  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_irq_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start || irq) begin
            r_svc     <= !start;
            r_op      <= 2'd0;
            r_busy    <= 1'b1;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_nxt_addr;
            r_pwrite  <= w_nxt_write;
            r_pwdata  <= w_nxt_wdata;
            r_state   <= S_SETUP;
            if (start) begin
              r_size     <= cfg_size;
              r_offset   <= cfg_offset;
              r_clr      <= cfg_clr;
              r_irqen    <= cfg_irqen;
              r_err_code <= EC_NONE;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_tmo     <= TW'(1);
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_abort) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= w_abort_code;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (pready) begin
            if (r_svc && (r_op == OP_RD_IRQ)) begin
              r_irq_rd <= prdata[4:0];
            end
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_GAP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_GAP: begin
          if (w_last) begin
            r_state <= S_DONE;
            if (r_svc) begin
              r_irq_status <= r_irq_rd;
              r_irq_valid  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            r_op      <= r_op + 2'd1;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_nxt_addr;
            r_pwrite  <= w_nxt_write;
            r_pwdata  <= w_nxt_wdata;
            r_state   <= S_SETUP;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfs_cfg_seq.sv
// tb/tb_cfs_cfg_seq.sv - directed bench for cfs_cfg_seq with a behavioural APB slave
module tb_cfs_cfg_seq;

  logic        pclk = 1'b0;
  logic        preset;
  logic        start;
  logic [2:0]  cfg_size;
  logic [1:0]  cfg_offset;
  logic        cfg_clr;
  logic [4:0]  cfg_irqen;
  logic        irq;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  irq_status;
  logic        irq_valid;

  int passed = 0;
  int total  = 0;

  // slave model state
  int          sl_delay;
  logic        sl_err_en;
  logic [15:0] sl_err_addr;
  logic        sl_stall_en;
  logic [15:0] sl_stall_addr;
  logic [31:0] sl_corrupt;
  logic [31:0] ctrl_reg;
  logic [31:0] irqen_reg;
  logic [4:0]  irq_reg;
  logic        irq_force;
  int          acc_cnt;
  logic [48:0] log_e [64];
  int          log_n;

  cfs_cfg_seq dut (
    .pclk(pclk), .preset(preset), .start(start),
    .cfg_size(cfg_size), .cfg_offset(cfg_offset), .cfg_clr(cfg_clr), .cfg_irqen(cfg_irqen),
    .irq(irq), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .irq_status(irq_status), .irq_valid(irq_valid)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // APB slave, evaluated on the falling edge
  task automatic slave_step();
    logic [31:0] rd;
    if (psel && penable) begin
      acc_cnt++;
      if (acc_cnt >= sl_delay && !(sl_stall_en && paddr == sl_stall_addr)) begin
        pready  = 1'b1;
        pslverr = sl_err_en && (paddr == sl_err_addr);
        rd = 32'h0;
        if (!pwrite) begin
          case (paddr)
            16'h0000: rd = ctrl_reg ^ sl_corrupt;
            16'h00f0: rd = irqen_reg;
            16'h00f4: rd = irq_force ? 32'h0 : {27'b0, irq_reg};
            default:  rd = 32'h0;
          endcase
        end else if (!pslverr) begin
          case (paddr)
            16'h0000: ctrl_reg = pwdata;
            16'h00f0: irqen_reg = pwdata;
            16'h00f4: begin
              irq_reg   = irq_reg & ~pwdata[4:0];
              irq_force = 1'b0;
            end
            default: ;
          endcase
        end
        prdata = rd;
        if (log_n < 64) log_e[log_n] = {paddr, pwrite, pwrite ? pwdata : rd};
        log_n++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
    end else begin
      acc_cnt = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end
    irq = irq_force || (irq_reg != 5'h0);
  endtask

  task automatic pulse_start(input logic [2:0] sz, input logic [1:0] off, input logic clr, input logic [4:0] ie);
    cfg_size   = sz;
    cfg_offset = off;
    cfg_clr    = clr;
    cfg_irqen  = ie;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_event(input int bound, output int n, output logic gd, output logic ge, output logic gi);
    n = 0; gd = 0; ge = 0; gi = 0;
    while (n < bound && !(gd || ge || gi)) begin
      tick();
      n++;
      gd = done; ge = err; gi = irq_valid;
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) tick();
    total++; if ({psel, penable, pwrite, busy, done, err, irq_valid} !== 7'b0) $display("FAIL rst_ctl got %b exp 0", {psel, penable, pwrite, busy, done, err, irq_valid}); else passed++;
    total++; if (paddr !== 16'h0) $display("FAIL rst_paddr got %h exp 0", paddr); else passed++;
    total++; if (pwdata !== 32'h0) $display("FAIL rst_pwdata got %h exp 0", pwdata); else passed++;
    total++; if ({err_code, irq_status} !== 7'h0) $display("FAIL rst_status got %h exp 0", {err_code, irq_status}); else passed++;
    preset = 1'b0;
    tick();
  endtask

  task automatic test_cfg_ok();
    int base, n;
    logic gd, ge, gi;
    sl_delay = 2;
    base = log_n;
    pulse_start(3'd4, 2'd0, 1'b0, 5'h1F);
    total++; if ({psel, penable, busy, pwrite} !== 4'b1011) $display("FAIL t1_setup got %b exp 1011", {psel, penable, busy, pwrite}); else passed++;
    total++; if (pwdata !== 32'h4) $display("FAIL t1_setup_wdata got %h exp 00000004", pwdata); else passed++;
    tick();
    total++; if ({psel, penable} !== 2'b11) $display("FAIL t1_access got %b exp 11", {psel, penable}); else passed++;
    wait_event(60, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b100) $display("FAIL t1_events got %b exp 100", {gd, ge, gi}); else passed++;
    total++; if (n !== 11) $display("FAIL t1_latency got %0d exp 11", n); else passed++;
    total++; if (log_n - base !== 3) $display("FAIL t1_xfers got %0d exp 3", log_n - base); else passed++;
    total++; if (log_e[base] !== {16'h0000, 1'b1, 32'h4}) $display("FAIL t1_wr_ctrl got %h exp %h", log_e[base], {16'h0000, 1'b1, 32'h4}); else passed++;
    total++; if (log_e[base+1] !== {16'h00f0, 1'b1, 32'h1F}) $display("FAIL t1_wr_irqen got %h exp %h", log_e[base+1], {16'h00f0, 1'b1, 32'h1F}); else passed++;
    total++; if (log_e[base+2] !== {16'h0000, 1'b0, 32'h4}) $display("FAIL t1_rd_ctrl got %h exp %h", log_e[base+2], {16'h0000, 1'b0, 32'h4}); else passed++;
    tick();
    total++; if ({done, busy, err_code} !== 4'b0) $display("FAIL t1_after got %b exp 0000", {done, busy, err_code}); else passed++;
  endtask

  task automatic test_slverr();
    int base, n;
    logic gd, ge, gi;
    sl_delay = 2; sl_err_en = 1'b1; sl_err_addr = 16'h0000;
    base = log_n;
    pulse_start(3'd3, 2'd1, 1'b0, 5'h0);
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b010) $display("FAIL t2_events got %b exp 010", {gd, ge, gi}); else passed++;
    total++; if (n !== 3) $display("FAIL t2_latency got %0d exp 3", n); else passed++;
    total++; if (err_code !== 2'd1) $display("FAIL t2_err_code got %0d exp 1", err_code); else passed++;
    total++; if ({psel, penable, busy} !== 3'b0) $display("FAIL t2_bus got %b exp 000", {psel, penable, busy}); else passed++;
    total++; if (log_n - base !== 1) $display("FAIL t2_xfers got %0d exp 1", log_n - base); else passed++;
    total++; if (log_e[base] !== {16'h0000, 1'b1, 32'h103}) $display("FAIL t2_wr_ctrl got %h exp %h", log_e[base], {16'h0000, 1'b1, 32'h103}); else passed++;
    tick();
    total++; if ({err, err_code} !== 3'b001) $display("FAIL t2_held got %b exp 001", {err, err_code}); else passed++;
    sl_err_en = 1'b0;
  endtask

  task automatic test_timeout();
    int base, n;
    logic gd, ge, gi;
    sl_delay = 1000;
    base = log_n;
    pulse_start(3'd4, 2'd0, 1'b0, 5'h1);
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b010) $display("FAIL t3_events got %b exp 010", {gd, ge, gi}); else passed++;
    total++; if (n !== 17) $display("FAIL t3_latency got %0d exp 17", n); else passed++;
    total++; if (err_code !== 2'd2) $display("FAIL t3_err_code got %0d exp 2", err_code); else passed++;
    total++; if ({psel, penable, busy} !== 3'b0) $display("FAIL t3_bus got %b exp 000", {psel, penable, busy}); else passed++;
    total++; if (log_n - base !== 0) $display("FAIL t3_xfers got %0d exp 0", log_n - base); else passed++;
    sl_delay = 1;
    base = log_n;
    pulse_start(3'd5, 2'd3, 1'b1, 5'h3);
    total++; if (err_code !== 2'd0) $display("FAIL t3_code_clear got %0d exp 0", err_code); else passed++;
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b100) $display("FAIL t3_rerun got %b exp 100", {gd, ge, gi}); else passed++;
    total++; if (n !== 9) $display("FAIL t3_rerun_latency got %0d exp 9", n); else passed++;
    total++; if (log_e[base] !== {16'h0000, 1'b1, 32'h10305}) $display("FAIL t3_wr_ctrl got %h exp %h", log_e[base], {16'h0000, 1'b1, 32'h10305}); else passed++;
    tick();
  endtask

  task automatic test_irq();
    int base, n;
    logic gd, ge, gi;
    sl_delay = 1;
    base = log_n;
    irq_reg = 5'h9;
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b001) $display("FAIL t4_events got %b exp 001", {gd, ge, gi}); else passed++;
    total++; if (n !== 7) $display("FAIL t4_latency got %0d exp 7", n); else passed++;
    total++; if (irq_status !== 5'h09) $display("FAIL t4_status got %h exp 09", irq_status); else passed++;
    total++; if (log_e[base] !== {16'h00f4, 1'b0, 32'h9}) $display("FAIL t4_rd_irq got %h exp %h", log_e[base], {16'h00f4, 1'b0, 32'h9}); else passed++;
    total++; if (log_e[base+1] !== {16'h00f4, 1'b1, 32'h9}) $display("FAIL t4_wr_irq got %h exp %h", log_e[base+1], {16'h00f4, 1'b1, 32'h9}); else passed++;
    repeat (4) tick();
    total++; if ({busy, irq_valid, irq, done} !== 4'b0) $display("FAIL t4_after got %b exp 0000", {busy, irq_valid, irq, done}); else passed++;
    total++; if (log_n - base !== 2) $display("FAIL t4_xfers got %0d exp 2", log_n - base); else passed++;
    // irq high but IRQ reads as zero: the write-back still happens
    base = log_n;
    irq_force = 1'b1;
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b001) $display("FAIL t4z_events got %b exp 001", {gd, ge, gi}); else passed++;
    total++; if (irq_status !== 5'h00) $display("FAIL t4z_status got %h exp 00", irq_status); else passed++;
    total++; if (log_e[base+1] !== {16'h00f4, 1'b1, 32'h0}) $display("FAIL t4z_wr_irq got %h exp %h", log_e[base+1], {16'h00f4, 1'b1, 32'h0}); else passed++;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int base, n;
    logic gd, ge, gi;
    sl_delay = 1;
    base = log_n;
    irq_reg = 5'h2;
    pulse_start(3'd4, 2'd0, 1'b0, 5'h3);
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b100) $display("FAIL t5_cfg got %b exp 100", {gd, ge, gi}); else passed++;
    tick();
    tick();
    total++; if ({psel, penable, pwrite, paddr} !== {3'b100, 16'h00f4}) $display("FAIL t5_svc_setup got %h exp %h", {psel, penable, pwrite, paddr}, {3'b100, 16'h00f4}); else passed++;
    pulse_start(3'd1, 2'd1, 1'b1, 5'h1);
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b001) $display("FAIL t5_svc got %b exp 001", {gd, ge, gi}); else passed++;
    total++; if (irq_status !== 5'h02) $display("FAIL t5_status got %h exp 02", irq_status); else passed++;
    repeat (4) tick();
    total++; if (log_n - base !== 5) $display("FAIL t5_xfers got %0d exp 5", log_n - base); else passed++;
    total++; if (log_e[base] !== {16'h0000, 1'b1, 32'h4}) $display("FAIL t5_first got %h exp %h", log_e[base], {16'h0000, 1'b1, 32'h4}); else passed++;
    total++; if (log_e[base+3] !== {16'h00f4, 1'b0, 32'h2}) $display("FAIL t5_rd_irq got %h exp %h", log_e[base+3], {16'h00f4, 1'b0, 32'h2}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t5_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int base, n;
    logic gd, ge, gi;
    logic found;
    sl_delay = 1; sl_stall_en = 1'b1; sl_stall_addr = 16'h00f0;
    pulse_start(3'd4, 2'd0, 1'b0, 5'h1F);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = psel && penable && (paddr == 16'h00f0);
    end
    total++; if (found !== 1'b1) $display("FAIL t6_reach_irqen got %b exp 1", found); else passed++;
    preset = 1'b1;
    tick();
    total++; if ({psel, penable, pwrite, busy, done, err, irq_valid} !== 7'b0) $display("FAIL t6_rst_ctl got %b exp 0", {psel, penable, pwrite, busy, done, err, irq_valid}); else passed++;
    total++; if ({paddr, pwdata} !== 48'h0) $display("FAIL t6_rst_bus got %h exp 0", {paddr, pwdata}); else passed++;
    total++; if ({err_code, irq_status} !== 7'h0) $display("FAIL t6_rst_status got %h exp 0", {err_code, irq_status}); else passed++;
    preset = 1'b0; sl_stall_en = 1'b0;
    tick();
    sl_corrupt = 32'h100;
    base = log_n;
    pulse_start(3'd4, 2'd0, 1'b0, 5'h0);
    wait_event(40, n, gd, ge, gi);
    total++; if ({gd, ge, gi} !== 3'b010) $display("FAIL t6_mm_events got %b exp 010", {gd, ge, gi}); else passed++;
    total++; if (n !== 8) $display("FAIL t6_mm_latency got %0d exp 8", n); else passed++;
    total++; if (err_code !== 2'd3) $display("FAIL t6_mm_code got %0d exp 3", err_code); else passed++;
    total++; if (log_n - base !== 3) $display("FAIL t6_mm_xfers got %0d exp 3", log_n - base); else passed++;
    sl_corrupt = 32'h0;
    tick();
  endtask

  initial begin
    preset = 1'b1; start = 1'b0;
    cfg_size = '0; cfg_offset = '0; cfg_clr = 1'b0; cfg_irqen = '0;
    irq = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    sl_delay = 1; sl_err_en = 1'b0; sl_err_addr = '0;
    sl_stall_en = 1'b0; sl_stall_addr = '0; sl_corrupt = '0;
    ctrl_reg = '0; irqen_reg = '0; irq_reg = '0; irq_force = 1'b0;
    acc_cnt = 0; log_n = 0;
    fork
      forever begin
        @(negedge pclk);
        slave_step();
      end
    join_none
    test_reset();
    test_cfg_ok();
    test_slverr();
    test_timeout();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
